// File: rtl/qs_stack_mb.sv
// Multi-bank hardware stack: BANKS_N independent LIFOs of DEPTH_N x W entries
// with push, pop, replace-top, per-bank clear and overflow/underflow reporting.
module qs_stack_mb #(
    parameter int W       = 32,
    parameter int DEPTH_N = 8,
    parameter int BANKS_N = 4,
    localparam int BW = (BANKS_N > 1) ? $clog2(BANKS_N) : 1,
    localparam int LW = $clog2(DEPTH_N + 1),
    localparam int AW = $clog2(DEPTH_N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_vld,
    output logic               cmd_rdy,
    input  logic [BW-1:0]      cmd_bank,
    input  logic               cmd_push,
    input  logic               cmd_pop,
    input  logic [W-1:0]       cmd_dat,
    input  logic               clr_vld,
    input  logic [BW-1:0]      clr_bank,
    output logic               rsp_vld,
    output logic [BW-1:0]      rsp_bank,
    output logic [W-1:0]       rsp_dat,
    output logic               rsp_err,
    output logic               err_ovf,
    output logic [BANKS_N-1:0] empty_r,
    output logic [BANKS_N-1:0] full_r
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH_N);

    logic [W-1:0]                mem_q [BANKS_N][DEPTH_N];
    logic [BANKS_N-1:0][LW-1:0]  lvl_q, lvl_d;
    logic [BANKS_N-1:0]          empty_q, empty_d, full_q, full_d;
    logic                        rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
    logic                        ovf_q, ovf_d;
    logic [BW-1:0]               rsp_bank_q, rsp_bank_d;
    logic [W-1:0]                rsp_dat_q, rsp_dat_d;

    logic          acc, we;
    logic [AW-1:0] we_idx, top_idx, wr_idx;
    logic [LW-1:0] sel_lvl;

    // A clear to the same bank wins; the issuer must hold the blocked command.
    assign cmd_rdy = ~(clr_vld & (clr_bank == cmd_bank));
    assign acc     = cmd_vld & cmd_rdy;
    assign sel_lvl = lvl_q[cmd_bank];
    assign top_idx = AW'(sel_lvl - LW'(1));
    assign wr_idx  = AW'(sel_lvl);

    always_comb begin
        lvl_d      = lvl_q;
        we         = 1'b0;
        we_idx     = '0;
        rsp_vld_d  = 1'b0;
        rsp_err_d  = 1'b0;
        rsp_bank_d = '0;
        rsp_dat_d  = '0;
        ovf_d      = 1'b0;
        if (acc && cmd_push && cmd_pop) begin
            rsp_vld_d  = 1'b1;
            rsp_bank_d = cmd_bank;
            we         = 1'b1;
            if (sel_lvl != '0) begin
                rsp_dat_d = mem_q[cmd_bank][top_idx];
                we_idx    = top_idx;
            end else begin
                rsp_err_d       = 1'b1;
                we_idx          = '0;
                lvl_d[cmd_bank] = LW'(1);
            end
        end else if (acc && cmd_push) begin
            if (sel_lvl != FULL_LVL) begin
                we              = 1'b1;
                we_idx          = wr_idx;
                lvl_d[cmd_bank] = sel_lvl + LW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (acc && cmd_pop) begin
            rsp_vld_d  = 1'b1;
            rsp_bank_d = cmd_bank;
            if (sel_lvl != '0) begin
                rsp_dat_d       = mem_q[cmd_bank][top_idx];
                lvl_d[cmd_bank] = sel_lvl - LW'(1);
            end else begin
                rsp_err_d = 1'b1;
            end
        end
        if (clr_vld) begin
            lvl_d[clr_bank] = '0;
        end
        for (int b = 0; b < BANKS_N; b++) begin
            empty_d[b] = (lvl_d[b] == '0);
            full_d[b]  = (lvl_d[b] == FULL_LVL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q      <= '0;
            empty_q    <= '1;
            full_q     <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
            rsp_bank_q <= '0;
            rsp_dat_q  <= '0;
        end else begin
            lvl_q      <= lvl_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            ovf_q      <= ovf_d;
            rsp_bank_q <= rsp_bank_d;
            rsp_dat_q  <= rsp_dat_d;
        end
    end

    // Storage is deliberately not reset; levels alone define valid contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[cmd_bank][we_idx] <= cmd_dat;
        end
    end

    assign rsp_vld  = rsp_vld_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_bank = rsp_bank_q;
    assign rsp_dat  = rsp_dat_q;
    assign err_ovf  = ovf_q;
    assign empty_r  = empty_q;
    assign full_r   = full_q;

endmodule

// File: tb/tb_qs_stack_mb.sv
// Directed self-checking bench for qs_stack_mb (W=32, DEPTH_N=8, BANKS_N=4).
module tb_qs_stack_mb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld, cmd_rdy, cmd_push, cmd_pop, clr_vld;
    logic [1:0]  cmd_bank, clr_bank, rsp_bank;
    logic [31:0] cmd_dat, rsp_dat;
    logic        rsp_vld, rsp_err, err_ovf;
    logic [3:0]  empty_r, full_r;

    int checks   = 0;
    int failures = 0;

    qs_stack_mb #(.W(32), .DEPTH_N(8), .BANKS_N(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_bank(cmd_bank),
        .cmd_push(cmd_push), .cmd_pop(cmd_pop), .cmd_dat(cmd_dat),
        .clr_vld(clr_vld), .clr_bank(clr_bank),
        .rsp_vld(rsp_vld), .rsp_bank(rsp_bank), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .err_ovf(err_ovf),
        .empty_r(empty_r), .full_r(full_r)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One command across one edge; outputs afterwards reflect that edge.
    task automatic cmd_op(input logic [1:0] b, input logic pu, input logic po,
                          input logic [31:0] d);
        cmd_vld = 1'b1; cmd_bank = b; cmd_push = pu; cmd_pop = po; cmd_dat = d;
        tick();
        cmd_vld = 1'b0; cmd_push = 1'b0; cmd_pop = 1'b0; cmd_dat = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_vld = 0; cmd_push = 0; cmd_pop = 0; cmd_bank = 0; cmd_dat = 0;
        clr_vld = 0; clr_bank = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (empty_r !== 4'hF || full_r !== 4'h0) begin
            failures++;
            $display("FAIL reset_flags empty=%h full=%h exp empty=f full=0", empty_r, full_r);
        end
        checks++;
        if (rsp_vld !== 0 || rsp_err !== 0 || err_ovf !== 0 || rsp_dat !== 0 || rsp_bank !== 0) begin
            failures++;
            $display("FAIL reset_outputs vld=%b err=%b ovf=%b dat=%h bank=%0d exp all 0",
                     rsp_vld, rsp_err, err_ovf, rsp_dat, rsp_bank);
        end
        checks++;
        if (cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_rdy got=%b exp=1", cmd_rdy);
        end
    endtask

    task automatic test_lifo();
        logic [31:0] exp_q [3];
        exp_q[0] = 32'hC; exp_q[1] = 32'hB; exp_q[2] = 32'hA;
        cmd_op(2'd1, 1, 0, 32'hA);
        cmd_op(2'd1, 1, 0, 32'hB);
        cmd_op(2'd1, 1, 0, 32'hC);
        checks++;
        if (empty_r !== 4'b1101) begin
            failures++;
            $display("FAIL lifo_empty_after_push got=%b exp=1101", empty_r);
        end
        for (int i = 0; i < 3; i++) begin
            cmd_op(2'd1, 0, 1, 32'h0);
            checks++;
            if (rsp_vld !== 1 || rsp_err !== 0 || rsp_bank !== 2'd1 || rsp_dat !== exp_q[i]) begin
                failures++;
                $display("FAIL lifo_pop%0d vld=%b err=%b bank=%0d dat=%h exp vld=1 err=0 bank=1 dat=%h",
                         i, rsp_vld, rsp_err, rsp_bank, rsp_dat, exp_q[i]);
            end
        end
        tick();
        checks++;
        if (rsp_vld !== 0 || empty_r !== 4'hF) begin
            failures++;
            $display("FAIL lifo_end vld=%b empty=%b exp vld=0 empty=1111", rsp_vld, empty_r);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) cmd_op(2'd0, 1, 0, 32'h100 + i);
        checks++;
        if (full_r !== 4'b0001 || err_ovf !== 0) begin
            failures++;
            $display("FAIL ovf_full_after8 full=%b ovf=%b exp full=0001 ovf=0", full_r, err_ovf);
        end
        cmd_op(2'd0, 1, 0, 32'h999);
        checks++;
        if (err_ovf !== 1 || full_r !== 4'b0001) begin
            failures++;
            $display("FAIL ovf_pulse ovf=%b full=%b exp ovf=1 full=0001", err_ovf, full_r);
        end
        tick();
        checks++;
        if (err_ovf !== 0) begin
            failures++;
            $display("FAIL ovf_not_sticky got=%b exp=0", err_ovf);
        end
        cmd_op(2'd0, 0, 1, 32'h0);
        checks++;
        if (rsp_vld !== 1 || rsp_err !== 0 || rsp_dat !== 32'h107 || full_r !== 4'b0000) begin
            failures++;
            $display("FAIL ovf_pop vld=%b err=%b dat=%h full=%b exp vld=1 err=0 dat=107 full=0000",
                     rsp_vld, rsp_err, rsp_dat, full_r);
        end
        clr_vld = 1; clr_bank = 2'd0;
        tick();
        clr_vld = 0;
        checks++;
        if (empty_r !== 4'hF) begin
            failures++;
            $display("FAIL ovf_clear empty=%b exp=1111", empty_r);
        end
    endtask

    task automatic test_underflow();
        cmd_op(2'd2, 0, 1, 32'h0);
        checks++;
        if (rsp_vld !== 1 || rsp_err !== 1 || rsp_dat !== 0 || rsp_bank !== 2'd2 || empty_r !== 4'hF) begin
            failures++;
            $display("FAIL underflow vld=%b err=%b dat=%h bank=%0d empty=%b exp 1 1 0 2 1111",
                     rsp_vld, rsp_err, rsp_dat, rsp_bank, empty_r);
        end
        tick();
        checks++;
        if (rsp_vld !== 0 || rsp_err !== 0) begin
            failures++;
            $display("FAIL underflow_pulse vld=%b err=%b exp 0 0", rsp_vld, rsp_err);
        end
    endtask

    task automatic test_replace();
        cmd_op(2'd3, 1, 0, 32'h5);
        cmd_op(2'd3, 1, 1, 32'h7);
        checks++;
        if (rsp_vld !== 1 || rsp_err !== 0 || rsp_dat !== 32'h5 || empty_r !== 4'b0111) begin
            failures++;
            $display("FAIL replace_top vld=%b err=%b dat=%h empty=%b exp 1 0 5 0111",
                     rsp_vld, rsp_err, rsp_dat, empty_r);
        end
        cmd_op(2'd3, 0, 1, 32'h0);
        checks++;
        if (rsp_dat !== 32'h7 || rsp_err !== 0 || empty_r !== 4'hF) begin
            failures++;
            $display("FAIL replace_pop dat=%h err=%b empty=%b exp 7 0 1111", rsp_dat, rsp_err, empty_r);
        end
        cmd_op(2'd3, 1, 1, 32'hBEEF);
        checks++;
        if (rsp_vld !== 1 || rsp_err !== 1 || rsp_dat !== 0 || empty_r !== 4'b0111) begin
            failures++;
            $display("FAIL replace_empty vld=%b err=%b dat=%h empty=%b exp 1 1 0 0111",
                     rsp_vld, rsp_err, rsp_dat, empty_r);
        end
        cmd_op(2'd3, 0, 1, 32'h0);
        checks++;
        if (rsp_dat !== 32'hBEEF || rsp_err !== 0 || empty_r !== 4'hF) begin
            failures++;
            $display("FAIL replace_empty_pop dat=%h err=%b empty=%b exp beef 0 1111",
                     rsp_dat, rsp_err, empty_r);
        end
    endtask

    task automatic test_clear();
        cmd_op(2'd1, 1, 0, 32'h11);
        cmd_op(2'd0, 1, 0, 32'h22);
        clr_vld = 1; clr_bank = 2'd1;
        cmd_vld = 1; cmd_bank = 2'd1; cmd_push = 1; cmd_dat = 32'h33;
        #1;
        checks++;
        if (cmd_rdy !== 0) begin
            failures++;
            $display("FAIL clear_rdy_same_bank got=%b exp=0", cmd_rdy);
        end
        tick();
        checks++;
        if (empty_r !== 4'b1110 || err_ovf !== 0 || rsp_vld !== 0) begin
            failures++;
            $display("FAIL clear_blocks_push empty=%b ovf=%b vld=%b exp 1110 0 0", empty_r, err_ovf, rsp_vld);
        end
        cmd_bank = 2'd0; cmd_push = 0; cmd_pop = 1; cmd_dat = 0;
        #1;
        checks++;
        if (cmd_rdy !== 1) begin
            failures++;
            $display("FAIL clear_rdy_other_bank got=%b exp=1", cmd_rdy);
        end
        tick();
        clr_vld = 0; cmd_vld = 0; cmd_pop = 0;
        checks++;
        if (rsp_vld !== 1 || rsp_bank !== 2'd0 || rsp_dat !== 32'h22 || empty_r !== 4'hF) begin
            failures++;
            $display("FAIL clear_other_pop vld=%b bank=%0d dat=%h empty=%b exp 1 0 22 1111",
                     rsp_vld, rsp_bank, rsp_dat, empty_r);
        end
    endtask

    task automatic test_mid_reset();
        cmd_op(2'd2, 1, 0, 32'h44);
        cmd_op(2'd2, 1, 0, 32'h45);
        cmd_op(2'd2, 0, 1, 32'h0);
        checks++;
        if (rsp_vld !== 1 || rsp_dat !== 32'h45) begin
            failures++;
            $display("FAIL mreset_pre vld=%b dat=%h exp 1 45", rsp_vld, rsp_dat);
        end
        // Pop pending while reset asserts asynchronously before its edge.
        cmd_vld = 1; cmd_bank = 2'd2; cmd_pop = 1;
        rst = 1;
        #1;
        checks++;
        if (rsp_vld !== 0 || rsp_dat !== 0 || empty_r !== 4'hF) begin
            failures++;
            $display("FAIL mreset_async vld=%b dat=%h empty=%b exp 0 0 1111", rsp_vld, rsp_dat, empty_r);
        end
        tick();
        cmd_vld = 0; cmd_pop = 0;
        checks++;
        if (rsp_vld !== 0 || empty_r !== 4'hF || full_r !== 0) begin
            failures++;
            $display("FAIL mreset_held vld=%b empty=%b full=%b exp 0 1111 0000", rsp_vld, empty_r, full_r);
        end
        rst = 0;
        tick();
        cmd_op(2'd2, 0, 1, 32'h0);
        checks++;
        if (rsp_vld !== 1 || rsp_err !== 1 || rsp_dat !== 0) begin
            failures++;
            $display("FAIL mreset_fresh_pop vld=%b err=%b dat=%h exp 1 1 0", rsp_vld, rsp_err, rsp_dat);
        end
        cmd_op(2'd2, 1, 0, 32'h55);
        cmd_op(2'd2, 0, 1, 32'h0);
        checks++;
        if (rsp_vld !== 1 || rsp_err !== 0 || rsp_dat !== 32'h55 || empty_r !== 4'hF) begin
            failures++;
            $display("FAIL mreset_push_pop vld=%b err=%b dat=%h empty=%b exp 1 0 55 1111",
                     rsp_vld, rsp_err, rsp_dat, empty_r);
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_replace();
        test_clear();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
